// File: rtl/bcd_convert_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_convert_arbiter_pkg
//   Shared definitions for the BCD conversion arbiter: controller state
//   encoding and the operand / digit widths used by the top and the decoder.
// -----------------------------------------------------------------------------
package bcd_convert_arbiter_pkg;

   localparam int OP_W  = 8;  // binary operand width
   localparam int BCD_W = 4;  // width of one BCD digit on the response port
   localparam int HUN_W = 2;  // hundreds digit of an 8-bit value never exceeds 2

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_convert_arbiter_dec.sv
// -----------------------------------------------------------------------------
// bcd_convert_arbiter_dec
//   Combinational 8-bit binary to BCD decoder (shift-and-add-3).
//
//   Ports:
//     bin_i       [7:0]  unsigned operand, 0..255
//     hundreds_o  [1:0]  hundreds digit, 0..2
//     tens_o      [3:0]  tens digit, 0..9
//     ones_o      [3:0]  ones digit, 0..9
// -----------------------------------------------------------------------------
module bcd_convert_arbiter_dec
   import bcd_convert_arbiter_pkg::*;
(
   input  logic [OP_W-1:0]  bin_i,
   output logic [HUN_W-1:0] hundreds_o,
   output logic [BCD_W-1:0] tens_o,
   output logic [BCD_W-1:0] ones_o
);

   logic [OP_W-1:0]  bin;
   logic [HUN_W-1:0] hun;
   logic [BCD_W-1:0] tens;
   logic [BCD_W-1:0] ones;

   // NOTE: every variable written here gets a value before any condition,
   // so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      bin  = bin_i;
      hun  = '0;
      tens = '0;
      ones = '0;
      for (int i = 0; i < OP_W; i++) begin
         // A digit of 5 or more would become >= 10 after the shift; adding 3
         // first makes the shift carry into the next decade instead.
         if (ones >= 4'd5) ones = ones + 4'd3;
         if (tens >= 4'd5) tens = tens + 4'd3;
         // hun is at most 1 before the last shift, so its MSB is never lost.
         hun  = {hun[0], tens[3]};
         tens = {tens[2:0], ones[3]};
         ones = {ones[2:0], bin[7]};
         bin  = {bin[6:0], 1'b0};
      end
   end

   assign hundreds_o = hun;
   assign tens_o     = tens;
   assign ones_o     = ones;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_convert_arbiter
//   Shares one binary-to-BCD decoder between NREQ requesters. A round-robin
//   pick in IDLE grants one requester and registers its operand; DECODE
//   registers the decoder result; RESP holds it on a valid/ready port until
//   accepted. One conversion is in flight at a time.
//
//   Ports:
//     clk           rising-edge clock
//     reset         synchronous, active-high reset
//     req_valid     [NREQ]     per-requester request
//     req_data      [8*NREQ]   operand i in bits [8i+7:8i]
//     req_ready     [NREQ]     one-hot grant pulse (IDLE only)
//     rsp_valid                result available
//     rsp_ready                consumer accepts result
//     rsp_id        [IDW]      requester index of the result
//     rsp_hundreds  [4]        BCD hundreds (0..2)
//     rsp_tens      [4]        BCD tens
//     rsp_ones      [4]        BCD ones
//     busy                     high outside IDLE
// -----------------------------------------------------------------------------
module bcd_convert_arbiter
   import bcd_convert_arbiter_pkg::*;
#(
   parameter  int NREQ = 3,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [OP_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [BCD_W-1:0]     rsp_hundreds,
   output logic [BCD_W-1:0]     rsp_tens,
   output logic [BCD_W-1:0]     rsp_ones,
   output logic                 busy
);

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [BCD_W-1:0] hun_q, hun_d;
   logic [BCD_W-1:0] tens_q, tens_d;
   logic [BCD_W-1:0] ones_q, ones_d;

   // Round-robin pick results
   logic             grant_found;
   logic [IDW-1:0]   grant_idx;
   logic [IDW-1:0]   grant_next;
   logic [OP_W-1:0]  grant_data;

   // Decoder outputs
   logic [HUN_W-1:0] dec_hundreds;
   logic [BCD_W-1:0] dec_hundreds_ext;
   logic [BCD_W-1:0] dec_tens;
   logic [BCD_W-1:0] dec_ones;

   bcd_convert_arbiter_dec u_dec (
      .bin_i      (op_q),
      .hundreds_o (dec_hundreds),
      .tens_o     (dec_tens),
      .ones_o     (dec_ones)
   );

   assign dec_hundreds_ext = {{(BCD_W-HUN_W){1'b0}}, dec_hundreds};

   // First valid requester scanning from rr_ptr upward, wrapping at NREQ.
   // The found flag stops later matches, so at most one index is chosen.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_next  = '0;
      grant_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
            grant_next  = IDW'((idx + 1) % NREQ);
            grant_data  = req_data[idx*OP_W +: OP_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_d        = op_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      hun_d       = hun_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      req_ready   = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               op_d     = grant_data;
               id_d     = grant_idx;
               rr_ptr_d = grant_next;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            hun_d       = dec_hundreds_ext;
            tens_d      = dec_tens;
            ones_d      = dec_ones;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;  // unused encoding recovers to IDLE
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the values from before this edge, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         op_q        <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         hun_q       <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_q        <= op_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         hun_q       <= hun_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_hundreds = hun_q;
   assign rsp_tens     = tens_q;
   assign rsp_ones     = ones_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_convert_arbiter
//   Requester agent serves per-requester operand queues; a cycle model of the
//   arbiter predicts grants, pushes expected results into a scoreboard at
//   grant time and compares them while the response is presented.
// -----------------------------------------------------------------------------
module tb_bcd_convert_arbiter;

   localparam int NREQ = 3;
   localparam int IDW  = $clog2(NREQ);

   typedef enum int {M_IDLE, M_DECODE, M_RESP} mstate_e;
   typedef struct {
      int         id;
      logic [7:0] val;
   } sb_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_hundreds;
   logic [3:0]        rsp_tens;
   logic [3:0]        rsp_ones;
   logic              busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  pend [NREQ][$];
   sb_t         sb [$];
   mstate_e     m_state = M_IDLE;
   int          m_ptr = 0;
   logic [NREQ-1:0] granted = '0;
   int          rsp_mode = 0;   // 0: ready high, 1: random, 2: ready low
   bit          chk_rst = 1'b0;

   bcd_convert_arbiter #(.NREQ(NREQ)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_hundreds (rsp_hundreds),
      .rsp_tens     (rsp_tens),
      .rsp_ones     (rsp_ones),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Requester agent: holds each queued operand until its grant is seen.
   initial begin : agent
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++)
            if (granted[i] && pend[i].size() > 0) void'(pend[i].pop_front());
         for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = (pend[i].size() > 0);
            req_data[i*8 +: 8] = req_valid[i] ? pend[i][0] : 8'd0;
         end
         case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // Cycle model and scoreboard, sampled on the falling edge.
   initial begin : monitor
      logic [NREQ-1:0] exp_g;
      int              g;
      sb_t             e;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            sb.delete();
            granted = '0;
            chk_rst = 1'b1;
         end else begin
            if (chk_rst) begin
               check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
               check("rst_rsp_id", 32'(rsp_id), 32'd0);
               check("rst_hundreds", 32'(rsp_hundreds), 32'd0);
               check("rst_tens", 32'(rsp_tens), 32'd0);
               check("rst_ones", 32'(rsp_ones), 32'd0);
               check("rst_busy", 32'(busy), 32'd0);
               chk_rst = 1'b0;
            end
            check("onehot", 32'($countones(req_ready) <= 1), 32'd1);
            check("busy", 32'(busy), 32'(m_state != M_IDLE));
            case (m_state)
               M_IDLE: begin
                  exp_g = '0;
                  g     = -1;
                  for (int k = 0; k < NREQ; k++) begin
                     int idx;
                     idx = (m_ptr + k) % NREQ;
                     if (g < 0 && req_valid[idx]) g = idx;
                  end
                  if (g >= 0) exp_g[g] = 1'b1;
                  check("req_ready", 32'(req_ready), 32'(exp_g));
                  check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                  if (g >= 0) begin
                     sb.push_back('{id: g, val: pend[g][0]});
                     m_ptr   = (g + 1) % NREQ;
                     m_state = M_DECODE;
                  end
               end
               M_DECODE: begin
                  check("req_ready_decode", 32'(req_ready), 32'd0);
                  check("rsp_valid_decode", 32'(rsp_valid), 32'd0);
                  m_state = M_RESP;
               end
               default: begin
                  check("req_ready_resp", 32'(req_ready), 32'd0);
                  check("rsp_valid_resp", 32'(rsp_valid), 32'd1);
                  check("sb_depth", 32'(sb.size()), 32'd1);
                  if (sb.size() > 0) begin
                     e = sb[0];
                     check("rsp_id", 32'(rsp_id), 32'(e.id));
                     check("hundreds", 32'(rsp_hundreds), 32'(e.val / 8'd100));
                     check("tens", 32'(rsp_tens), 32'((e.val / 8'd10) % 8'd10));
                     check("ones", 32'(rsp_ones), 32'(e.val % 8'd10));
                     if (rsp_ready) void'(sb.pop_front());
                  end
                  if (rsp_ready) m_state = M_IDLE;
               end
            endcase
            granted = req_ready;
         end
      end
   end

   task automatic wait_state(input mstate_e s, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (m_state != s && n < budget);
      check("wait_state", 32'(m_state), 32'(s));
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      int left;
      do begin
         @(negedge clk);
         #1;
         n++;
         left = sb.size();
         for (int i = 0; i < NREQ; i++) left += pend[i].size();
      end while ((left != 0 || m_state != M_IDLE) && n < budget);
      check("drain_left", 32'(left), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : main
      logic [7:0] sweep [7] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd254, 8'd255};
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Simultaneous requests: served 0, 1, 2, then 0 again
      @(negedge clk);
      #1;
      pend[0].push_back(8'd0);
      pend[0].push_back(8'd42);
      pend[1].push_back(8'd100);
      pend[2].push_back(8'd199);
      wait_idle(200);

      // Single request
      pend[1].push_back(8'd255);
      wait_idle(50);

      // Backpressure with competing requests pending
      rsp_mode = 2;
      pend[0].push_back(8'd123);
      wait_state(M_RESP, 50);
      pend[1].push_back(8'd7);
      pend[2].push_back(8'd8);
      repeat (4) begin
         @(negedge clk);
         #1;
      end
      rsp_mode = 0;
      wait_idle(100);

      // Reset while DECODE; requester 1 granted so rr_ptr was non-zero
      rsp_mode = 2;
      pend[1].push_back(8'd77);
      wait_state(M_DECODE, 50);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      pend[0].push_back(8'd5);
      pend[2].push_back(8'd6);
      rsp_mode = 0;
      wait_idle(100);

      // Reset while RESP
      rsp_mode = 2;
      pend[1].push_back(8'd200);
      wait_state(M_RESP, 50);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      pend[0].push_back(8'd31);
      pend[2].push_back(8'd64);
      rsp_mode = 0;
      wait_idle(100);

      // Boundary sweep from a lone requester
      foreach (sweep[i]) pend[2].push_back(sweep[i]);
      wait_idle(100);

      // All values across random requesters with random stalls
      rsp_mode = 1;
      for (int v = 0; v < 256; v++) pend[$urandom_range(0, NREQ-1)].push_back(8'(v));
      wait_idle(20000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
